// File: rtl/date_pkg.sv
// Shared types, field encodings and calendar arithmetic for the date entry
// front end and the calendar core.
package date_pkg;

  // Edit FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StEditYear,
    StEditMonth,
    StEditDay,
    StLoad
  } state_e;

  // Encoding of the field output; drives the display blink selection.
  localparam logic [1:0] FIELD_YEAR  = 2'd0;
  localparam logic [1:0] FIELD_MONTH = 2'd1;
  localparam logic [1:0] FIELD_DAY   = 2'd2;
  localparam logic [1:0] FIELD_NONE  = 2'd3;

  localparam logic [6:0] YEAR_MAX  = 7'd99;
  localparam logic [3:0] MONTH_MAX = 4'd12;

  // Last valid day of a month; leap selects the 29-day February.
  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
    logic [4:0] max_day;
    case (month)
      4'd2:                    max_day = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: max_day = 5'd30;
      default:                 max_day = 5'd31;
    endcase
    return max_day;
  endfunction

endpackage

// File: rtl/date_entry_if.sv
// Load bus between the date entry front end (writer) and the calendar core
// (reader/counter). The date fields are only meaningful while load_valid is high.
interface date_entry_if;

  logic       load_valid;
  logic       load_ready;
  logic [6:0] year_out;
  logic [3:0] month_out;
  logic [4:0] day_out;

  // Date entry side: offers the date.
  modport master (
    output load_valid,
    output year_out,
    output month_out,
    output day_out,
    input  load_ready
  );

  // Calendar side: accepts the date.
  modport slave (
    input  load_valid,
    input  year_out,
    input  month_out,
    input  day_out,
    output load_ready
  );

endinterface

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a one-cycle
// pulse on each accepted press (debounced 1->0). Releases produce no pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_press;
  logic [CntW-1:0] r_cnt;

  logic w_mismatch;
  logic w_flip;

  assign w_mismatch = (r_sync2 != r_level);
  // Flip on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
  assign w_flip     = w_mismatch && (r_cnt == CntLast);

  // Bring the raw button into the clock domain; released (1) out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive mismatches; any agreeing sample restarts the run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= w_flip && r_level;
      if (w_flip) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else if (w_mismatch) begin
        r_cnt   <= r_cnt + CntW'(1);
      end else begin
        r_cnt   <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/date_entry.sv
// Date entry front end: edit FSM over year/month/day driven by two debounced
// buttons, with day clamping to the month length and a valid/ready load offer.
module date_entry
  import date_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic              ADC_CLK_10,
  input  logic              reset_n,
  input  logic              btn_adj_n,
  input  logic              btn_next_n,
  input  logic              edit_en,
  input  logic              dir,
  output logic [1:0]        field,
  output logic              editing,
  date_entry_if.master      load_if
);

  logic       r_en_s1;
  logic       r_en_s2;
  logic       r_en_prev;
  logic       r_dir_s1;
  logic       r_dir_s2;
  state_e     r_state;
  logic [6:0] r_year;
  logic [3:0] r_month;
  logic [4:0] r_day;

  logic       w_adj_press;
  logic       w_adj_level;
  logic       w_next_press;
  logic       w_next_level;
  logic       w_en_rise;
  state_e     w_state_nxt;
  logic [6:0] w_year_nxt;
  logic [3:0] w_month_nxt;
  logic [4:0] w_day_nxt;
  logic [4:0] w_max_cur;
  logic [4:0] w_max_nxt;
  logic [6:0] w_year_step;
  logic [3:0] w_month_step;
  logic [4:0] w_day_step;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_adj (
    .i_clk   (ADC_CLK_10),
    .i_rst_n (reset_n),
    .i_btn_n (btn_adj_n),
    .o_level (w_adj_level),
    .o_press (w_adj_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_next (
    .i_clk   (ADC_CLK_10),
    .i_rst_n (reset_n),
    .i_btn_n (btn_next_n),
    .o_level (w_next_level),
    .o_press (w_next_press)
  );

  // Synchronize the switch levels; r_en_prev gives the rising-edge detector.
  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      r_en_s1   <= 1'b0;
      r_en_s2   <= 1'b0;
      r_en_prev <= 1'b0;
      r_dir_s1  <= 1'b0;
      r_dir_s2  <= 1'b0;
    end else begin
      r_en_s1   <= edit_en;
      r_en_s2   <= r_en_s1;
      r_en_prev <= r_en_s2;
      r_dir_s1  <= dir;
      r_dir_s2  <= r_dir_s1;
    end
  end

  assign w_en_rise = r_en_s2 && !r_en_prev;
  assign w_max_cur = days_in_month(r_month, r_year[1:0] == 2'b00);

  // One wrapping step of each field in the synchronized direction.
  always_comb begin
    w_year_step  = r_year;
    w_month_step = r_month;
    w_day_step   = r_day;
    if (r_dir_s2) begin
      w_year_step  = (r_year == YEAR_MAX) ? 7'd0 : r_year + 7'd1;
      w_month_step = (r_month == MONTH_MAX) ? 4'd1 : r_month + 4'd1;
      w_day_step   = (r_day >= w_max_cur) ? 5'd1 : r_day + 5'd1;
    end else begin
      w_year_step  = (r_year == 7'd0) ? YEAR_MAX : r_year - 7'd1;
      w_month_step = (r_month <= 4'd1) ? MONTH_MAX : r_month - 4'd1;
      w_day_step   = (r_day <= 5'd1) ? w_max_cur : r_day - 5'd1;
    end
  end

  // Next state and field updates; abort beats next, next beats adjust.
  always_comb begin
    w_state_nxt = r_state;
    w_year_nxt  = r_year;
    w_month_nxt = r_month;
    w_day_nxt   = r_day;
    case (r_state)
      StIdle: begin
        if (w_en_rise) w_state_nxt = StEditYear;
      end
      StEditYear: begin
        if (!r_en_s2)          w_state_nxt = StIdle;
        else if (w_next_press) w_state_nxt = StEditMonth;
        else if (w_adj_press)  w_year_nxt  = w_year_step;
      end
      StEditMonth: begin
        if (!r_en_s2)          w_state_nxt = StIdle;
        else if (w_next_press) w_state_nxt = StEditDay;
        else if (w_adj_press)  w_month_nxt = w_month_step;
      end
      StEditDay: begin
        if (!r_en_s2)          w_state_nxt = StIdle;
        else if (w_next_press) w_state_nxt = StLoad;
        else if (w_adj_press)  w_day_nxt   = w_day_step;
      end
      StLoad: begin
        // Fields are frozen here; edit_en is deliberately ignored.
        if (load_if.load_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    // Keep the day legal for whatever year/month is about to be registered.
    w_max_nxt = days_in_month(w_month_nxt, w_year_nxt[1:0] == 2'b00);
    if (w_day_nxt > w_max_nxt) w_day_nxt = w_max_nxt;
  end

  // State and date registers.
  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_year  <= 7'd0;
      r_month <= 4'd1;
      r_day   <= 5'd1;
    end else begin
      r_state <= w_state_nxt;
      r_year  <= w_year_nxt;
      r_month <= w_month_nxt;
      r_day   <= w_day_nxt;
    end
  end

  // Decode state into the offer and display outputs.
  always_comb begin
    load_if.load_valid = 1'b0;
    field              = FIELD_NONE;
    editing            = 1'b0;
    case (r_state)
      StEditYear: begin
        field   = FIELD_YEAR;
        editing = 1'b1;
      end
      StEditMonth: begin
        field   = FIELD_MONTH;
        editing = 1'b1;
      end
      StEditDay: begin
        field   = FIELD_DAY;
        editing = 1'b1;
      end
      StLoad:  load_if.load_valid = 1'b1;
      default: ;
    endcase
  end

  assign load_if.year_out  = r_year;
  assign load_if.month_out = r_month;
  assign load_if.day_out   = r_day;

  // A press pulse always coincides with the debounced level having gone low.
  a_adj_press_low : assert property (@(posedge ADC_CLK_10) disable iff (!reset_n)
    w_adj_press |-> !w_adj_level);
  a_next_press_low : assert property (@(posedge ADC_CLK_10) disable iff (!reset_n)
    w_next_press |-> !w_next_level);

endmodule

// File: tb/tb_date_entry.sv
// Bench for date_entry: directed vector table, hand-written corner sequences
// and a randomized run against an arithmetic model of the field rules.
module tb_date_entry;

  localparam int unsigned DB = 4;

  typedef enum int {OpAdj, OpNext, OpEnter, OpAbort} op_e;

  typedef struct {
    op_e op;
    bit  dir;
    int  reps;
    int  year;
    int  month;
    int  day;
    int  fld;
    bit  editing;
    bit  valid;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_adj_n = 1'b1;
  logic       btn_next_n = 1'b1;
  logic       edit_en = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] field;
  logic       editing;

  date_entry_if u_if ();

  date_entry #(
    .DEBOUNCE_CYCLES (DB)
  ) u_dut (
    .ADC_CLK_10 (clk),
    .reset_n    (rst_n),
    .btn_adj_n  (btn_adj_n),
    .btn_next_n (btn_next_n),
    .edit_en    (edit_en),
    .dir        (dir),
    .field      (field),
    .editing    (editing),
    .load_if    (u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid_cyc = 0;

  // Model: date fields plus mode 0..2 = editing that field, 3 = idle, 4 = load.
  int m_year, m_month, m_day, m_mode;

  vec_t vecs[24];

  always @(posedge clk) if (u_if.load_valid === 1'b1) n_valid_cyc <= n_valid_cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int y, input int m, input int d,
                         input int fld, input int ed, input int v);
    chk($sformatf("%s.year", tag), int'(u_if.year_out), y);
    chk($sformatf("%s.month", tag), int'(u_if.month_out), m);
    chk($sformatf("%s.day", tag), int'(u_if.day_out), d);
    chk($sformatf("%s.field", tag), int'(field), fld);
    chk($sformatf("%s.editing", tag), int'(editing), ed);
    chk($sformatf("%s.load_valid", tag), int'(u_if.load_valid), v);
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_year, m_month, m_day, (m_mode < 3) ? m_mode : 3,
            (m_mode < 3) ? 1 : 0, (m_mode == 4) ? 1 : 0);
  endtask

  function automatic int dim(input int m, input int y);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic model_adj(input bit d);
    int mx;
    case (m_mode)
      0: m_year = d ? (m_year + 1) % 100 : (m_year + 99) % 100;
      1: m_month = d ? m_month % 12 + 1 : (m_month + 10) % 12 + 1;
      2: begin
        mx = dim(m_month, m_year);
        m_day = d ? m_day % mx + 1 : (m_day + mx - 2) % mx + 1;
      end
      default: ;
    endcase
    if (m_day > dim(m_month, m_year)) m_day = dim(m_month, m_year);
  endtask

  // Full press: hold long enough to be accepted, then a clean release.
  task automatic press(input bit is_next, input bit d);
    dir = d;
    if (is_next) btn_next_n = 1'b0;
    else btn_adj_n = 1'b0;
    ticks(8);
    btn_next_n = 1'b1;
    btn_adj_n  = 1'b1;
    ticks(8);
  endtask

  task automatic do_op(input op_e op, input bit d);
    case (op)
      OpAdj:  press(1'b0, d);
      OpNext: press(1'b1, d);
      OpEnter: begin
        edit_en = 1'b0;
        ticks(4);
        edit_en = 1'b1;
        ticks(5);
      end
      default: begin
        edit_en = 1'b0;
        ticks(5);
      end
    endcase
  endtask

  initial begin
    int snap;
    int r;
    bit d;

    vecs[0]  = '{OpNext,  1'b0, 1,  99, 1,  1,  1, 1'b1, 1'b0};
    vecs[1]  = '{OpAdj,   1'b1, 11, 99, 12, 1,  1, 1'b1, 1'b0};
    vecs[2]  = '{OpAdj,   1'b1, 1,  99, 1,  1,  1, 1'b1, 1'b0};
    vecs[3]  = '{OpAbort, 1'b1, 1,  99, 1,  1,  3, 1'b0, 1'b0};
    vecs[4]  = '{OpEnter, 1'b1, 1,  99, 1,  1,  0, 1'b1, 1'b0};
    vecs[5]  = '{OpAdj,   1'b1, 4,  3,  1,  1,  0, 1'b1, 1'b0};
    vecs[6]  = '{OpNext,  1'b1, 1,  3,  1,  1,  1, 1'b1, 1'b0};
    vecs[7]  = '{OpNext,  1'b1, 1,  3,  1,  1,  2, 1'b1, 1'b0};
    vecs[8]  = '{OpAdj,   1'b1, 30, 3,  1,  31, 2, 1'b1, 1'b0};
    vecs[9]  = '{OpAdj,   1'b1, 1,  3,  1,  1,  2, 1'b1, 1'b0};
    vecs[10] = '{OpAdj,   1'b0, 1,  3,  1,  31, 2, 1'b1, 1'b0};
    vecs[11] = '{OpAbort, 1'b0, 1,  3,  1,  31, 3, 1'b0, 1'b0};
    vecs[12] = '{OpEnter, 1'b0, 1,  3,  1,  31, 0, 1'b1, 1'b0};
    vecs[13] = '{OpNext,  1'b0, 1,  3,  1,  31, 1, 1'b1, 1'b0};
    vecs[14] = '{OpAdj,   1'b0, 1,  3,  12, 31, 1, 1'b1, 1'b0};
    vecs[15] = '{OpAdj,   1'b0, 1,  3,  11, 30, 1, 1'b1, 1'b0};
    vecs[16] = '{OpAdj,   1'b0, 9,  3,  2,  28, 1, 1'b1, 1'b0};
    vecs[17] = '{OpAbort, 1'b0, 1,  3,  2,  28, 3, 1'b0, 1'b0};
    vecs[18] = '{OpEnter, 1'b0, 1,  3,  2,  28, 0, 1'b1, 1'b0};
    vecs[19] = '{OpAdj,   1'b1, 1,  4,  2,  28, 0, 1'b1, 1'b0};
    vecs[20] = '{OpNext,  1'b1, 1,  4,  2,  28, 1, 1'b1, 1'b0};
    vecs[21] = '{OpNext,  1'b1, 1,  4,  2,  28, 2, 1'b1, 1'b0};
    vecs[22] = '{OpAdj,   1'b1, 1,  4,  2,  29, 2, 1'b1, 1'b0};
    vecs[23] = '{OpAdj,   1'b1, 1,  4,  2,  1,  2, 1'b1, 1'b0};

    // Reset values, both during and just after reset.
    ticks(3);
    chk_all("reset", 0, 1, 1, 3, 0, 0);
    rst_n = 1'b1;
    ticks(3);
    chk_all("post_reset", 0, 1, 1, 3, 0, 0);

    do_op(OpEnter, 1'b0);
    chk_all("enter", 0, 1, 1, 0, 1, 0);

    // 3-cycle glitch must not be accepted.
    btn_adj_n = 1'b0;
    ticks(3);
    btn_adj_n = 1'b1;
    ticks(12);
    chk("glitch.year", int'(u_if.year_out), 0);

    // 10-cycle hold: pulse 6 cycles after the raw edge, field updates one later.
    btn_adj_n = 1'b0;
    ticks(6);
    chk("latency.before", int'(u_if.year_out), 0);
    tick();
    chk("latency.after", int'(u_if.year_out), 99);
    ticks(3);
    btn_adj_n = 1'b1;
    ticks(12);
    chk("single_pulse.year", int'(u_if.year_out), 99);

    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < vecs[i].reps; k++) do_op(vecs[i].op, vecs[i].dir);
      chk_all($sformatf("vec%0d", i), vecs[i].year, vecs[i].month, vecs[i].day,
              vecs[i].fld, int'(vecs[i].editing), int'(vecs[i].valid));
    end
    m_year = 4; m_month = 2; m_day = 1; m_mode = 2;

    // Simultaneous adj and next in EDIT_MONTH: next wins, month untouched.
    do_op(OpAbort, 1'b0);
    do_op(OpEnter, 1'b0);
    do_op(OpNext, 1'b1);
    dir = 1'b1;
    btn_adj_n  = 1'b0;
    btn_next_n = 1'b0;
    ticks(8);
    btn_adj_n  = 1'b1;
    btn_next_n = 1'b1;
    ticks(8);
    chk_all("simul", 4, 2, 1, 2, 1, 0);

    // Abort from EDIT_DAY: straight to idle, never offering the date.
    snap = n_valid_cyc;
    do_op(OpAbort, 1'b0);
    ticks(3);
    chk("abort.valid_cycles", n_valid_cyc - snap, 0);
    chk_all("abort", 4, 2, 1, 3, 0, 0);

    // Load held off by load_ready = 0, then a one-cycle transfer.
    do_op(OpEnter, 1'b0);
    do_op(OpAdj, 1'b1);
    do_op(OpNext, 1'b1);
    do_op(OpNext, 1'b1);
    do_op(OpNext, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all($sformatf("hold%0d", i), 5, 2, 1, 3, 0, 1);
    end
    u_if.load_ready = 1'b1;
    #1;
    chk("xfer.valid", int'(u_if.load_valid), 1);
    tick();
    u_if.load_ready = 1'b0;
    chk_all("xfer.done", 5, 2, 1, 3, 0, 0);

    // Presses in IDLE are ignored.
    do_op(OpAdj, 1'b1);
    do_op(OpNext, 1'b1);
    chk_all("idle_press", 5, 2, 1, 3, 0, 0);

    // load_ready already high on entry: exactly one cycle of load_valid.
    do_op(OpEnter, 1'b0);
    do_op(OpNext, 1'b1);
    do_op(OpNext, 1'b1);
    u_if.load_ready = 1'b1;
    snap = n_valid_cyc;
    do_op(OpNext, 1'b1);
    u_if.load_ready = 1'b0;
    chk("fast_load.valid_cycles", n_valid_cyc - snap, 1);
    chk_all("fast_load", 5, 2, 1, 3, 0, 0);
    m_year = 5; m_mode = 3;

    // Randomized walk against the model.
    for (int it = 0; it < 120; it++) begin
      if (m_mode == 3) begin
        if ($urandom_range(0, 3) == 0) begin
          do_op(OpAdj, 1'($urandom_range(0, 1)));
        end else begin
          do_op(OpEnter, 1'b0);
          m_mode = 0;
        end
      end else begin
        r = $urandom_range(0, 9);
        d = 1'($urandom_range(0, 1));
        if (r < 6) begin
          do_op(OpAdj, d);
          model_adj(d);
        end else if (r < 9) begin
          do_op(OpNext, d);
          m_mode = m_mode + 1;
          if (m_mode == 3) m_mode = 4;
        end else begin
          do_op(OpAbort, d);
          m_mode = 3;
        end
      end
      chk_model($sformatf("rnd%0d", it));
      if (m_mode == 4) begin
        ticks($urandom_range(0, 3));
        chk_model($sformatf("rnd%0d.wait", it));
        u_if.load_ready = 1'b1;
        tick();
        u_if.load_ready = 1'b0;
        m_mode = 3;
        chk_model($sformatf("rnd%0d.xfer", it));
      end
    end

    // Reset in LOAD: edit_en low has no effect there, reset clears at once.
    do_op(OpEnter, 1'b0);
    do_op(OpNext, 1'b1);
    do_op(OpNext, 1'b1);
    do_op(OpNext, 1'b1);
    edit_en = 1'b0;
    ticks(4);
    chk("load_en_low.valid", int'(u_if.load_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 1, 1, 3, 0, 0);
    ticks(2);
    rst_n = 1'b1;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial u_if.load_ready = 1'b0;

endmodule

// File: doc/date_entry.md
# date_entry

User date-entry front end for the calendar display design. Debounces two pushbuttons, walks an edit FSM over year, month and day fields set by the board switches, and keeps the day valid for the month and leap year. When editing is done it offers the new date to the calendar counter over a valid/ready load handshake. It is the writer side of the calendar's date registers; the calendar core remains the reader/counter.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized samples needed to accept a button level (5 ms at 10 MHz); benches use 4.
- ADC_CLK_10  in  1  sole clock, 10 MHz board clock.
- reset_n  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- btn_adj_n  in  1  raw active-low pushbutton, asynchronous: adjust current field.
- btn_next_n  in  1  raw active-low pushbutton, asynchronous: advance to next field.
- edit_en  in  1  switch level, asynchronous; 1 = editing permitted.
- dir  in  1  switch level; 1 = increment, 0 = decrement.
- load_ready  in  1  calendar accepts the date this cycle.
- load_valid  out  1  date on outputs is offered to the calendar.
- year_out  out  7  year 0..99, binary.
- month_out  out  4  month 1..12, binary.
- day_out  out  5  day 1..31, binary.
- field  out  2  0 = year, 1 = month, 2 = day, 3 = none; drives display blink.
- editing  out  1  high in any EDIT state.

## Operation
- edit_en and dir pass through 2-FF synchronizers before use.
- FSM states: IDLE, EDIT_YEAR, EDIT_MONTH, EDIT_DAY, LOAD.
  - IDLE → EDIT_YEAR on synchronized edit_en rising edge.
  - next press: EDIT_YEAR → EDIT_MONTH → EDIT_DAY → LOAD.
  - adj press in EDIT_x: the field is incremented or decremented per dir.
  - LOAD → IDLE on the cycle where load_valid and load_ready are both 1.
  - edit_en low in any EDIT state: abort to IDLE next cycle. No load occurs. The field registers keep their edited values.
  - edit_en low in LOAD has no effect; the offer completes.
- Field rules:
  - Year wraps 99 ↔ 0.
  - Month wraps 12 ↔ 1.
  - Day wraps max ↔ 1, where max = days_in_month(month, leap).
  - leap = (year[1:0] == 0).
  - February max is 29 if leap, else 28. April, June, September and November max is 30. All other months max is 31.
- Clamp: after any year or month change, if day_out > new max, day_out becomes max in the same cycle the field updates.
- Simultaneous adj and next pulses: next wins; the adj pulse is dropped.
- Presses in IDLE or LOAD are ignored.
- load_valid is high exactly in LOAD. year_out, month_out and day_out must not change while load_valid = 1.
- field = 3 and editing = 0 in IDLE and LOAD.
- Reset values: load_valid 0, year_out 0, month_out 1, day_out 1, field 3, editing 0, FSM IDLE, debounced button levels 1 (released), counters 0.

## Timing
- Debounce latency:
  - A raw button edge reaches the synchronized level 2 cycles later.
  - The debounced level flips after DEBOUNCE_CYCLES consecutive cycles of synchronized ≠ debounced.
  - A one-cycle press pulse is issued on a debounced 1→0 transition only; release produces no pulse.
- Any mismatch run shorter than DEBOUNCE_CYCLES resets the counter to 0, and no pulse is issued.
- The field register and FSM state update on the cycle after the press pulse.
- The load handshake holds indefinitely while load_ready = 0. If load_ready is already high on entry to LOAD, the transfer takes one cycle.
- Reset asserted mid-edit or mid-LOAD: all outputs return to reset values immediately, asynchronously. load_valid drops without a handshake.

## Structure
- Shared package date_pkg:
  - FSM state typedef.
  - Field encoding constants FIELD_YEAR, FIELD_MONTH, FIELD_DAY, FIELD_NONE.
  - YEAR_MAX = 99, MONTH_MAX = 12.
  - days_in_month(month, leap) function, also used by the calendar core.
- Sub-module key_debounce, instantiated twice:
  - Ports: clock, reset, raw active-low input, debounced level, press pulse.
  - Contains the 2-FF synchronizer and the DEBOUNCE_CYCLES counter.
- Top of block: FSM, field arithmetic, clamp and handshake. Total 150–300 lines.

## Test plan
- DEBOUNCE_CYCLES = 4:
  - Glitch btn_adj_n low for 3 cycles → no press pulse and no field change.
  - Hold low for 10 cycles → exactly one pulse, 6 cycles after the raw edge.
- edit_en = 1, dir = 0, year 0 → one adj press gives year 99. Then next, then dir = 1 with 12 adj presses → month returns to 1.
- Set year 3, month 1, day 31 (31 adj from day 1 with dir = 1, wrapping correctly). Set month 2 via decrement 1→12→…; verify day clamps to 28. Back in EDIT_YEAR, with year 4 verify Feb max is 29 (day 29 + inc → 1).
- Complete YEAR/MONTH/DAY with load_ready = 0 for 5 cycles → load_valid high and data stable for all 5 cycles. Raise load_ready → one-cycle transfer, then IDLE and load_valid = 0.
- Simultaneous adj and next pulses in EDIT_MONTH → state EDIT_DAY, month unchanged. edit_en dropped in EDIT_DAY → IDLE with no load_valid.
- Assert reset_n low during LOAD → load_valid 0 and outputs 0/1/1 before the next clock edge.
